// File: rtl/fifo_pkg.sv
// Shared FIFO-library helpers: width calculation and parameter legality.
package fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Depth must be a power of two so the pointers can wrap for free.
    function automatic bit params_legal(input int unsigned data_width,
                                        input int unsigned depth,
                                        input int unsigned af_thresh,
                                        input int unsigned ae_thresh);
        return (data_width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_thresh >= 1) && (af_thresh <= depth) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, asynchronous read, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_stream_fifo.sv
// Single-clock valid/ready FIFO, first-word-fall-through, with occupancy flags,
// synchronous flush and a high-water-mark monitor.
module sync_stream_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned DEPTH               = 16,
    parameter int unsigned ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic [clog2(DEPTH):0]   count,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   max_count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (!params_legal(DATA_WIDTH, DEPTH, ALMOST_FULL_THRESH, ALMOST_EMPTY_THRESH)) begin : g_bad_params
        $error("sync_stream_fifo: illegal DATA_WIDTH/DEPTH/threshold parameters");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         max_count_q, max_count_d;
    logic                  not_full_c, not_empty_c;
    logic                  push_c, pop_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    // Status decodes come only from registered count, never from the inputs.
    assign not_full_c   = (count_q != CW'(DEPTH));
    assign not_empty_c  = (count_q != '0);
    assign push_c       = in_valid && not_full_c;
    assign pop_c        = not_empty_c && out_ready;

    assign in_ready     = not_full_c;
    assign out_valid    = not_empty_c;
    assign out_data     = not_empty_c ? rd_data_c : '0;
    assign count        = count_q;
    assign max_count    = max_count_q;
    assign almost_full  = (count_q >= CW'(ALMOST_FULL_THRESH));
    assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_THRESH));

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_c && !flush),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data_c)
    );

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        max_count_d = max_count_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            max_count_d = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CW'(1);
            end
            if (count_d > max_count_q) begin
                max_count_d = count_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            max_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
        end
    end

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Randomised bench for sync_stream_fifo against a queue-based reference model.
module tb_sync_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [4:0]    count;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    max_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];
    int            max_m = 0;

    sync_stream_fifo #(
        .DATA_WIDTH          (DW),
        .DEPTH               (DEPTH),
        .ALMOST_FULL_THRESH  (AF),
        .ALMOST_EMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_count    (max_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return 1ns later.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        bit push_m, pop_m;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        push_m = v && (q.size() != DEPTH);
        pop_m  = r && (q.size() != 0);
        @(posedge clk);
        if (f) begin
            q.delete();
            max_m = 0;
        end else begin
            if (pop_m) popped.push_back(q.pop_front());
            if (push_m) q.push_back(d);
            if (q.size() > max_m) max_m = q.size();
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL reset_handshake got=%b%b exp=10", in_ready, out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_flags got=ae%b af%b exp=ae1 af0", almost_empty, almost_full); end
        total++; if (max_count !== 5'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", max_count); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
        total++; if (count !== 5'd5) begin bad++; $display("FAIL pre_reset_count got=%0d exp=5", count); end
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        q.delete(); max_m = 0;
        total++; if (count !== 5'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_count got=%0d/%b exp=0/0", count, out_valid); end
        total++; if (out_data !== 8'h00 || in_ready !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL async_reset_outs got=%0h/%b/%b exp=0/1/1", out_data, in_ready, almost_empty); end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1, DW'(i), 1'b0, 1'b0);
            total++; if (count !== 5'(i) || out_data !== 8'h01) begin bad++; $display("FAIL fill_step%0d got=%0d/%0h exp=%0d/1", i, count, out_data, i); end
        end
        total++; if (in_ready !== 1'b0 || almost_full !== 1'b1 || max_count !== 5'd16) begin bad++; $display("FAIL full_state got=ir%b af%b max%0d exp=ir0 af1 max16", in_ready, almost_full, max_count); end
        tick(1'b1, 8'h77, 1'b0, 1'b0);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL overfill_count got=%0d exp=16", count); end
        for (int i = 1; i <= DEPTH; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin bad++; $display("FAIL drain_word%0d got=%0h exp=%0h", i, out_data, i); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        total++; if (out_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_thresholds();
        for (int n = 0; n <= DEPTH; n++) begin
            total++; if (count !== 5'(n) || almost_full !== (n >= 12) || almost_empty !== (n <= 3)) begin
                bad++; $display("FAIL thresh_up n=%0d got=af%b ae%b exp=af%b ae%b", n, almost_full, almost_empty, n >= 12, n <= 3); end
            if (n < DEPTH) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
        end
        for (int n = DEPTH; n >= 0; n--) begin
            total++; if (count !== 5'(n) || almost_full !== (n >= 12) || almost_empty !== (n <= 3) || out_data !== exp_head()) begin
                bad++; $display("FAIL thresh_down n=%0d got=af%b ae%b d%0h exp=af%b ae%b d%0h", n, almost_full, almost_empty, out_data, n >= 12, n <= 3, exp_head()); end
            if (n > 0) tick(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] head;
        tick(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            head = exp_head();
            total++; if (count !== 5'd1 || out_data !== head) begin bad++; $display("FAIL b2b_cycle%0d got=%0d/%0h exp=1/%0h", i, count, out_data, head); end
            tick(1'b1, DW'($urandom), 1'b1, 1'b0);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        total++; if (count !== 5'd0) begin bad++; $display("FAIL b2b_end got=%0d exp=0", count); end
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] head;
        for (int i = 0; i < DEPTH; i++) tick(1'b1, DW'($urandom_range(0, 127)), 1'b0, 1'b0);
        head = exp_head();
        tick(1'b1, 8'hDA, 1'b1, 1'b0);
        total++; if (count !== 5'd15 || in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_only got=%0d/%b exp=15/1", count, in_ready); end
        total++; if (popped[$] !== head || q[$] === 8'hDA) begin bad++; $display("FAIL full_pop_word got=%0h exp=%0h", popped[$], head); end
        tick(1'b1, 8'hDA, 1'b0, 1'b0);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_repush got=%0d exp=16", count); end
        while (q.size() != 0) begin
            head = exp_head();
            total++; if (out_data !== head) begin bad++; $display("FAIL full_drain got=%0h exp=%0h", out_data, head); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) tick(1'b1, DW'($urandom_range(0, 127)), 1'b0, 1'b0);
        total++; if (count !== 5'd9) begin bad++; $display("FAIL flush_pre got=%0d exp=9", count); end
        tick(1'b1, 8'hEE, 1'b1, 1'b1);
        total++; if (count !== 5'd0 || max_count !== 5'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            bad++; $display("FAIL flush_clear got=c%0d m%0d v%b d%0h exp=c0 m0 v0 d0", count, max_count, out_valid, out_data); end
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 5'd1 || max_count !== 5'd1) begin
            bad++; $display("FAIL flush_after got=v%b d%0h c%0d m%0d exp=v1 dA5 c1 m1", out_valid, out_data, count, max_count); end
        tick(1'b0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        int bias;
        for (int i = 0; i < 600; i++) begin
            bias = (i / 100) % 2 == 0 ? 3 : 1;
            total++; if (count !== 5'(q.size()) || in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rand_status%0d got=c%0d ir%b ov%b exp=c%0d", i, count, in_ready, out_valid, q.size()); end
            total++; if (out_data !== exp_head() || max_count !== 5'(max_m)) begin
                bad++; $display("FAIL rand_data%0d got=d%0h m%0d exp=d%0h m%0d", i, out_data, max_count, exp_head(), max_m); end
            total++; if (almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE)) begin
                bad++; $display("FAIL rand_flags%0d got=af%b ae%b size=%0d", i, almost_full, almost_empty, q.size()); end
            tick(1'($urandom_range(0, 3) < bias + 1), DW'($urandom), 1'($urandom_range(0, 3) >= bias),
                 1'($urandom_range(0, 59) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_back_to_back();
        test_full_simul();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
